// File: rtl/muxn_arb_pkg.sv
// Shared definitions for the muxn_arb channel multiplexer.
// Mode encodings used on mode_i.
package muxn_arb_pkg;

  localparam logic MUX_MODE_FIXED = 1'b0;
  localparam logic MUX_MODE_RR    = 1'b1;

endpackage

// File: rtl/muxn_arb_rr_arbiter.sv
// Combinational round-robin search: first requesting channel at or above i_ptr,
// wrapping CHANNELS-1 -> 0 by explicit compare so any channel count works.
module muxn_arb_rr_arbiter
  import muxn_arb_pkg::*;
#(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned SELBITS  = 3
) (
  input  logic [CHANNELS-1:0] i_req,
  input  logic [SELBITS-1:0]  i_ptr,
  output logic [SELBITS-1:0]  o_gnt_idx,
  output logic                o_gnt_valid
);

  int unsigned w_pos;

  always_comb begin
    o_gnt_idx   = '0;
    o_gnt_valid = 1'b0;
    w_pos       = 0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      w_pos = 32'(i_ptr) + k;
      if (w_pos >= CHANNELS) w_pos = w_pos - CHANNELS;
      if (!o_gnt_valid && i_req[SELBITS'(w_pos)]) begin
        o_gnt_valid = 1'b1;
        o_gnt_idx   = SELBITS'(w_pos);
      end
    end
  end

endmodule

// File: rtl/muxn_arb.sv
// N-to-1 valid/ready channel multiplexer with fixed-select or round-robin
// arbitration feeding a one-deep output register.
module muxn_arb
  import muxn_arb_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned SELBITS  = 3
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      mode_i,
  input  logic [SELBITS-1:0]        sel_i,
  input  logic [CHANNELS-1:0]       valid_i,
  output logic [CHANNELS-1:0]       ready_o,
  input  logic [CHANNELS*WIDTH-1:0] data_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [WIDTH-1:0]          data_o,
  output logic [SELBITS-1:0]        chan_o
);

  logic               r_valid;
  logic [WIDTH-1:0]   r_data;
  logic [SELBITS-1:0] r_chan;
  logic [SELBITS-1:0] r_ptr;

  logic               w_load;
  logic               w_fix_ok;
  logic               w_rr_valid;
  logic               w_gnt;
  logic [SELBITS-1:0] w_rr_idx;
  logic [SELBITS-1:0] w_gnt_idx;
  logic [WIDTH-1:0]   w_data [CHANNELS];

  for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
    assign w_data[k] = data_i[k*WIDTH +: WIDTH];
  end

  muxn_arb_rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SELBITS  (SELBITS)
  ) u_rr (
    .i_req       (valid_i),
    .i_ptr       (r_ptr),
    .o_gnt_idx   (w_rr_idx),
    .o_gnt_valid (w_rr_valid)
  );

  // The register can take a word when empty or while its current word drains.
  assign w_load   = !r_valid || ready_i;
  assign w_fix_ok = (32'(sel_i) < CHANNELS) && valid_i[sel_i];

  always_comb begin
    w_gnt_idx = (mode_i == MUX_MODE_RR) ? w_rr_idx : sel_i;
    w_gnt     = !reset_i && w_load &&
                ((mode_i == MUX_MODE_RR) ? w_rr_valid : w_fix_ok);
    ready_o   = '0;
    if (w_gnt) ready_o[w_gnt_idx] = 1'b1;
  end

  // Output register and round-robin pointer; a stall simply holds everything.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
      r_ptr   <= '0;
    end else if (w_gnt) begin
      r_valid <= 1'b1;
      r_data  <= w_data[w_gnt_idx];
      r_chan  <= w_gnt_idx;
      if (mode_i == MUX_MODE_RR)
        r_ptr <= (32'(w_gnt_idx) == CHANNELS - 1) ? '0 : w_gnt_idx + SELBITS'(1);
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign chan_o  = r_chan;

endmodule

// File: tb/tb_muxn_arb.sv
// Bench for muxn_arb: directed scenarios plus randomized traffic against a
// behavioural model of the arbitration and output register.
module tb_muxn_arb;

  localparam int unsigned W   = 8;
  localparam int unsigned CH  = 8;
  localparam int unsigned SB  = 3;
  localparam int unsigned CH6 = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-channel instance
  logic          rst, mode, ri, vo;
  logic [SB-1:0] sel, cho;
  logic [CH-1:0] vld, rdy_o;
  logic [CH*W-1:0] din;
  logic [W-1:0]  dout;

  // 6-channel instance
  logic           rst6, mode6, ri6, vo6;
  logic [SB-1:0]  sel6, cho6;
  logic [CH6-1:0] vld6, rdy6_o;
  logic [CH6*W-1:0] din6;
  logic [W-1:0]   dout6;

  muxn_arb #(.WIDTH(W), .CHANNELS(CH), .SELBITS(SB)) dut (
    .clock_i(clk), .reset_i(rst), .mode_i(mode), .sel_i(sel),
    .valid_i(vld), .ready_o(rdy_o), .data_i(din), .valid_o(vo),
    .ready_i(ri), .data_o(dout), .chan_o(cho)
  );

  muxn_arb #(.WIDTH(W), .CHANNELS(CH6), .SELBITS(SB)) dut6 (
    .clock_i(clk), .reset_i(rst6), .mode_i(mode6), .sel_i(sel6),
    .valid_i(vld6), .ready_o(rdy6_o), .data_i(din6), .valid_o(vo6),
    .ready_i(ri6), .data_o(dout6), .chan_o(cho6)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model of the 8-channel instance
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = '0;
  logic [2:0] m_chan  = '0;
  int         m_ptr   = 0;

  function automatic logic [CH-1:0] exp_ready();
    logic [CH-1:0] r;
    r = '0;
    if (rst) return r;
    if (m_valid && !ri) return r;
    if (!mode) begin
      if (int'(sel) < int'(CH) && vld[sel]) r[sel] = 1'b1;
    end else begin
      for (int k = 0; k < int'(CH); k++) begin
        int c;
        c = (m_ptr + k) % int'(CH);
        if (vld[c]) begin
          r[c] = 1'b1;
          return r;
        end
      end
    end
    return r;
  endfunction

  // Advance one clock and step the model with the inputs held across the edge.
  task automatic tick();
    logic [CH-1:0] g;
    g = exp_ready();
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_chan = '0; m_ptr = 0;
    end else if (g != '0) begin
      for (int k = 0; k < int'(CH); k++) begin
        if (g[k]) begin
          m_valid = 1'b1;
          m_data  = din[k*8 +: 8];
          m_chan  = 3'(k);
          if (mode) m_ptr = (k + 1) % int'(CH);
        end
      end
    end else if (ri) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b1; vld = '1; ri = 1'b1;
    #1;
    checks++;
    if (rdy_o !== 8'h00) begin
      failures++; $display("FAIL reset_ready: got %h expected 00", rdy_o);
    end
    tick(); tick();
    checks++;
    if (vo !== 1'b0 || dout !== 8'h00 || cho !== 3'd0) begin
      failures++;
      $display("FAIL reset_state: got valid=%b data=%h chan=%0d expected 0/00/0", vo, dout, cho);
    end
    rst = 1'b0;
  endtask

  task automatic test_fixed();
    logic [2:0] sels [4];
    logic [7:0] exp_d [4];
    logic [7:0] exp_r [4];
    sels  = '{3'd1, 3'd2, 3'd7, 3'd5};
    exp_d = '{8'd6, 8'd5, 8'd0, 8'd2};
    exp_r = '{8'h02, 8'h04, 8'h80, 8'h20};
    mode = 1'b0; vld = '1; ri = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = sels[i];
      #1;
      checks++;
      if (rdy_o !== exp_r[i]) begin
        failures++; $display("FAIL fixed_ready[%0d]: got %h expected %h", i, rdy_o, exp_r[i]);
      end
      tick();
      checks++;
      if (dout !== exp_d[i] || cho !== sels[i] || vo !== 1'b1) begin
        failures++;
        $display("FAIL fixed_out[%0d]: got data=%0d chan=%0d valid=%b expected %0d/%0d/1",
                 i, dout, cho, vo, exp_d[i], sels[i]);
      end
    end
  endtask

  task automatic test_rr_all();
    mode = 1'b1; vld = '1; ri = 1'b1;
    for (int i = 0; i < 9; i++) begin
      logic [7:0] er;
      er = 8'h01 << (i % 8);
      #1;
      checks++;
      if (rdy_o !== er) begin
        failures++; $display("FAIL rr_all_ready[%0d]: got %h expected %h", i, rdy_o, er);
      end
      tick();
      checks++;
      if (cho !== 3'(i % 8) || vo !== 1'b1 || dout !== 8'(7 - (i % 8))) begin
        failures++;
        $display("FAIL rr_all_out[%0d]: got chan=%0d valid=%b data=%0d expected chan=%0d",
                 i, cho, vo, dout, i % 8);
      end
    end
  endtask

  task automatic test_rr_sparse();
    logic [2:0] exp_c [4];
    exp_c = '{3'd2, 3'd7, 3'd2, 3'd7};
    mode = 1'b1; vld = 8'b1000_0100; ri = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (cho !== exp_c[i] || vo !== 1'b1) begin
        failures++;
        $display("FAIL rr_sparse[%0d]: got chan=%0d valid=%b expected chan=%0d", i, cho, vo, exp_c[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    mode = 1'b1; vld = '1; ri = 1'b1;
    #1;
    tick();
    checks++;
    if (cho !== 3'd0 || dout !== 8'd7 || vo !== 1'b1) begin
      failures++; $display("FAIL bp_load: got chan=%0d data=%0d valid=%b expected 0/7/1", cho, dout, vo);
    end
    ri = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (rdy_o !== 8'h00) begin
        failures++; $display("FAIL bp_ready[%0d]: got %h expected 00", i, rdy_o);
      end
      tick();
      checks++;
      if (cho !== 3'd0 || dout !== 8'd7 || vo !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got chan=%0d data=%0d valid=%b expected 0/7/1", i, cho, dout, vo);
      end
    end
    ri = 1'b1;
    #1;
    checks++;
    if (rdy_o !== 8'h02) begin
      failures++; $display("FAIL bp_release_ready: got %h expected 02", rdy_o);
    end
    tick();
    checks++;
    if (cho !== 3'd1 || dout !== 8'd6 || vo !== 1'b1) begin
      failures++; $display("FAIL bp_release: got chan=%0d data=%0d valid=%b expected 1/6/1", cho, dout, vo);
    end
  endtask

  task automatic test_reset_mid_stall();
    ri = 1'b0; vld = '1; mode = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (rdy_o !== 8'h00) begin
      failures++; $display("FAIL rst_stall_ready: got %h expected 00", rdy_o);
    end
    tick();
    checks++;
    if (vo !== 1'b0 || dout !== 8'h00 || cho !== 3'd0) begin
      failures++;
      $display("FAIL rst_stall_state: got valid=%b data=%h chan=%0d expected 0/00/0", vo, dout, cho);
    end
    rst = 1'b0; ri = 1'b1;
    #1;
    checks++;
    if (rdy_o !== 8'h01) begin
      failures++; $display("FAIL rst_ptr_ready: got %h expected 01", rdy_o);
    end
    tick();
    checks++;
    if (cho !== 3'd0 || dout !== 8'd7 || vo !== 1'b1) begin
      failures++; $display("FAIL rst_ptr_grant: got chan=%0d data=%0d valid=%b expected 0/7/1", cho, dout, vo);
    end
  endtask

  task automatic test_invalid_sel();
    rst6 = 1'b0; mode6 = 1'b0; sel6 = 3'd7; vld6 = '1; ri6 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (rdy6_o !== 6'h00) begin
        failures++; $display("FAIL badsel_ready[%0d]: got %h expected 00", i, rdy6_o);
      end
      tick();
      checks++;
      if (vo6 !== 1'b0) begin
        failures++; $display("FAIL badsel_valid[%0d]: got %b expected 0", i, vo6);
      end
    end
    mode6 = 1'b1;
    #1;
    checks++;
    if (rdy6_o !== 6'h01) begin
      failures++; $display("FAIL badsel_rr_ready: got %h expected 01", rdy6_o);
    end
    tick();
    checks++;
    if (vo6 !== 1'b1 || cho6 !== 3'd0 || dout6 !== 8'd7) begin
      failures++;
      $display("FAIL badsel_rr_grant: got valid=%b chan=%0d data=%0d expected 1/0/7", vo6, cho6, dout6);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [CH-1:0] er;
      rst  = ($urandom_range(0, 39) == 0);
      mode = 1'($urandom);
      sel  = 3'($urandom);
      vld  = ($urandom_range(0, 2) == 0) ? 8'($urandom) & 8'($urandom) : 8'($urandom);
      ri   = ($urandom_range(0, 3) != 0);
      din  = {$urandom, $urandom};
      #1;
      er = exp_ready();
      checks++;
      if (rdy_o !== er) begin
        failures++; $display("FAIL rand_ready[%0d]: got %h expected %h", i, rdy_o, er);
      end
      tick();
      checks++;
      if (vo !== m_valid || dout !== m_data || cho !== m_chan) begin
        failures++;
        $display("FAIL rand_out[%0d]: got valid=%b data=%h chan=%0d expected %b/%h/%0d",
                 i, vo, dout, cho, m_valid, m_data, m_chan);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; sel = '0; vld = '0; ri = 1'b1;
    rst6 = 1'b1; mode6 = 1'b0; sel6 = '0; vld6 = '0; ri6 = 1'b1;
    for (int k = 0; k < int'(CH); k++) din[k*8 +: 8] = 8'(7 - k);
    for (int k = 0; k < int'(CH6); k++) din6[k*8 +: 8] = 8'(7 - k);
    @(negedge clk);
    test_reset();
    test_fixed();
    test_rr_all();
    test_rr_sparse();
    test_backpressure();
    test_reset_mid_stall();
    test_invalid_sel();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
